// File: rtl/lu_serial_driver.sv
// Bit-serial initiator for the 1-bit AND/NAND/OR/NOR logic unit: one operand bit per
// SETTLE+1 cycle window, result word returned on a valid/ready port.
module lu_serial_driver #(
  parameter int WIDTH  = 8,
  parameter int SETTLE = 1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [WIDTH-1:0] req_a,
  input  logic [WIDTH-1:0] req_b,
  input  logic [1:0]       req_op,
  output logic             lu_a,
  output logic             lu_b,
  output logic             lu_sel_t,
  output logic             lu_sel_an,
  output logic             lu_sel_on,
  input  logic             lu_sf,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_data,
  output logic             busy
);
  localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int SW = (SETTLE > 0) ? $clog2(SETTLE + 1) : 1;
  localparam logic [IW-1:0] LAST_IDX    = IW'(WIDTH - 1);
  localparam logic [SW-1:0] LAST_SETTLE = SW'(SETTLE);

  typedef enum logic [1:0] {S_IDLE, S_DRIVE, S_RESP} state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_a;       // operand bits not yet presented, LSB next
  logic [WIDTH-1:0] r_b;
  logic [IW-1:0]    r_idx;
  logic [SW-1:0]    r_settle;
  logic             w_accept;

  assign req_ready = reset_n && (r_state == S_IDLE);
  assign w_accept  = req_valid && req_ready;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state   <= S_IDLE;
      r_a       <= '0;
      r_b       <= '0;
      r_idx     <= '0;
      r_settle  <= '0;
      lu_a      <= 1'b0;
      lu_b      <= 1'b0;
      lu_sel_t  <= 1'b0;
      lu_sel_an <= 1'b0;
      lu_sel_on <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
      busy      <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            lu_a      <= req_a[0];
            lu_b      <= req_b[0];
            r_a       <= req_a >> 1;
            r_b       <= req_b >> 1;
            lu_sel_t  <= req_op[1];
            lu_sel_an <= req_op[0];
            lu_sel_on <= req_op[0];
            r_idx     <= '0;
            r_settle  <= '0;
            busy      <= 1'b1;
            r_state   <= S_DRIVE;
          end
        end
        S_DRIVE: begin
          if (r_settle == LAST_SETTLE) begin
            // Last cycle of the window: the LU output has settled on the held bit.
            rsp_data[r_idx] <= lu_sf;
            r_settle        <= '0;
            if (r_idx == LAST_IDX) begin
              rsp_valid <= 1'b1;
              r_state   <= S_RESP;
            end else begin
              r_idx <= r_idx + IW'(1);
              lu_a  <= r_a[0];
              lu_b  <= r_b[0];
              r_a   <= r_a >> 1;
              r_b   <= r_b >> 1;
            end
          end else begin
            r_settle <= r_settle + SW'(1);
          end
        end
        S_RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            busy      <= 1'b0;
            r_state   <= S_IDLE;
          end
        end
        default: begin
          rsp_valid <= 1'b0;
          busy      <= 1'b0;
          r_state   <= S_IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_lu_serial_driver.sv
// Directed bench for lu_serial_driver (WIDTH=8, SETTLE=1) with a behavioural LU and result scoreboard.
module tb_lu_serial_driver;
  localparam int WIDTH  = 8;
  localparam int SETTLE = 1;
  localparam int WIN    = SETTLE + 1;

  logic             clk = 1'b0;
  logic             reset_n = 1'b0;
  logic             req_valid = 1'b0;
  logic             rsp_ready = 1'b0;
  logic [WIDTH-1:0] req_a = '0;
  logic [WIDTH-1:0] req_b = '0;
  logic [1:0]       req_op = 2'b00;
  logic             req_ready, lu_a, lu_b, lu_sel_t, lu_sel_an, lu_sel_on, lu_sf;
  logic             rsp_valid, busy;
  logic [WIDTH-1:0] rsp_data;

  logic [WIDTH-1:0] exp_q[$];
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  // Stateless logic unit: group select picks AND/NAND or OR/NOR, the other select inverts.
  assign lu_sf = lu_sel_t ? (lu_sel_on ? ~(lu_a | lu_b) : (lu_a | lu_b))
                          : (lu_sel_an ? ~(lu_a & lu_b) : (lu_a & lu_b));

  lu_serial_driver #(.WIDTH(WIDTH), .SETTLE(SETTLE)) dut (
    .clk(clk), .reset_n(reset_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .req_op(req_op),
    .lu_a(lu_a), .lu_b(lu_b), .lu_sel_t(lu_sel_t), .lu_sel_an(lu_sel_an), .lu_sel_on(lu_sel_on),
    .lu_sf(lu_sf),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .busy(busy)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_idle_outputs(input string tag);
    chk({tag, "_lu_a"}, lu_a, 0);
    chk({tag, "_lu_b"}, lu_b, 0);
    chk({tag, "_sel_t"}, lu_sel_t, 0);
    chk({tag, "_sel_an"}, lu_sel_an, 0);
    chk({tag, "_sel_on"}, lu_sel_on, 0);
    chk({tag, "_rsp_valid"}, rsp_valid, 0);
    chk({tag, "_rsp_data"}, rsp_data, 0);
    chk({tag, "_busy"}, busy, 0);
  endtask

  // One full operation; chain keeps req_valid high with the next request queued behind it.
  task automatic run_op(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                        input logic [1:0] op, input logic [WIDTH-1:0] expv,
                        input int stall, input bit chain,
                        input logic [WIDTH-1:0] na, input logic [WIDTH-1:0] nb,
                        input logic [1:0] nop);
    int n;
    n = 0;
    req_a = a; req_b = b; req_op = op; req_valid = 1'b1;
    while (!req_ready && n < 50) begin
      tick();
      n++;
    end
    chk("accept_wait", (n < 50), 1);
    tick();
    exp_q.push_back(expv);
    if (chain) begin
      req_a = na; req_b = nb; req_op = nop;
    end else begin
      req_valid = 1'b0;
    end
    chk("busy_drive", busy, 1);
    chk("ready_drive", req_ready, 0);
    for (int k = 0; k < WIDTH * WIN; k++) begin
      chk("lu_a_bit", lu_a, a[k / WIN]);
      chk("lu_b_bit", lu_b, b[k / WIN]);
      chk("sel_t", lu_sel_t, op[1]);
      chk("sel_an", lu_sel_an, op[0]);
      chk("sel_on", lu_sel_on, op[0]);
      chk("no_early_rsp", rsp_valid, 0);
      if (k == 5 && !chain) begin
        req_a = ~a; req_b = ~b; req_op = ~op;
      end
      tick();
    end
    chk("rsp_latency", rsp_valid, 1);
    chk("rsp_data_first", rsp_data, exp_q[0]);
    for (int s = 0; s < stall; s++) begin
      if (s == 3) begin
        req_valid = 1'b1; req_a = 8'h12; req_b = 8'h34; req_op = 2'b01;
      end
      if (s == 4) req_valid = chain;
      tick();
      chk("stall_rsp_valid", rsp_valid, 1);
      chk("stall_rsp_data", rsp_data, exp_q[0]);
      chk("stall_req_ready", req_ready, 0);
      chk("stall_busy", busy, 1);
    end
    if (chain) begin
      req_a = na; req_b = nb; req_op = nop;
    end
    req_valid = chain;
    rsp_ready = 1'b1;
    chk("rsp_data_pop", rsp_data, exp_q.pop_front());
    tick();
    rsp_ready = 1'b0;
    chk("rsp_valid_drop", rsp_valid, 0);
    chk("ready_after_rsp", req_ready, 1);
    chk("busy_after_rsp", busy, 0);
  endtask

  initial begin
    reset_n = 1'b0;
    repeat (3) tick();
    chk("reset_req_ready", req_ready, 0);
    chk_idle_outputs("reset");
    reset_n = 1'b1;
    tick();
    chk("idle_req_ready", req_ready, 1);

    // Four opcodes on the same operands, one with a long response stall.
    run_op(8'hF0, 8'h3C, 2'b00, 8'h30, 0, 1'b0, 8'h00, 8'h00, 2'b00);
    run_op(8'hF0, 8'h3C, 2'b01, 8'hCF, 0, 1'b0, 8'h00, 8'h00, 2'b00);
    run_op(8'hF0, 8'h3C, 2'b10, 8'hFC, 10, 1'b0, 8'h00, 8'h00, 2'b00);
    run_op(8'hF0, 8'h3C, 2'b11, 8'h03, 2, 1'b0, 8'h00, 8'h00, 2'b00);

    // Abort during bit 3, then confirm nothing escapes.
    req_a = 8'hFF; req_b = 8'hFF; req_op = 2'b11; req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
    repeat (6) tick();
    chk("pre_abort_busy", busy, 1);
    chk("pre_abort_sel_t", lu_sel_t, 1);
    reset_n = 1'b0;
    #1;
    chk("abort_req_ready", req_ready, 0);
    tick();
    chk_idle_outputs("abort");
    reset_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick();
      chk("abort_no_rsp", rsp_valid, 0);
    end
    run_op(8'hAA, 8'h55, 2'b10, 8'hFF, 0, 1'b0, 8'h00, 8'h00, 2'b00);

    // Back-to-back with req_valid held high across the first response.
    run_op(8'hFF, 8'h0F, 2'b00, 8'h0F, 6, 1'b1, 8'h00, 8'h00, 2'b11);
    run_op(8'h00, 8'h00, 2'b11, 8'hFF, 0, 1'b0, 8'h00, 8'h00, 2'b00);

    tick();
    chk("final_idle_busy", busy, 0);
    chk("final_queue_empty", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
